// File: rtl/watch_pkg.sv
// Shared encodings, field limits, reset time and calendar helpers for the watch setter.
package watch_pkg;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StEdit   = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  localparam logic [2:0] FldYear   = 3'd0;
  localparam logic [2:0] FldMonth  = 3'd1;
  localparam logic [2:0] FldDay    = 3'd2;
  localparam logic [2:0] FldHour   = 3'd3;
  localparam logic [2:0] FldMinute = 3'd4;
  localparam logic [2:0] FldSecond = 3'd5;

  localparam logic [11:0] YearMin   = 12'd1;
  localparam logic [11:0] YearMax   = 12'd4095;
  localparam logic [11:0] MonthMax  = 12'd12;
  localparam logic [11:0] HourMax   = 12'd23;
  localparam logic [11:0] MinSecMax = 12'd59;

  localparam logic [11:0] RstYear   = 12'd2021;
  localparam logic [7:0]  RstMonth  = 8'd5;
  localparam logic [7:0]  RstDay    = 8'd30;
  localparam logic [7:0]  RstHour   = 8'd0;
  localparam logic [7:0]  RstMinute = 8'd0;
  localparam logic [7:0]  RstSecond = 8'd0;

  function automatic logic is_leap(input logic [11:0] y);
    return ((y[1:0] == 2'd0) && ((y % 12'd100) != 12'd0)) || ((y % 12'd400) == 12'd0);
  endfunction

  function automatic logic [7:0] max_date(input logic [11:0] y, input logic [7:0] m);
    case (m)
      8'd2:                      return is_leap(y) ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11:   return 8'd30;
      default:                   return 8'd31;
    endcase
  endfunction

  // Out-of-range values (e.g. an unclamped day) wrap like the upper bound.
  function automatic logic [11:0] wrap_step(input logic [11:0] v, input logic [11:0] lo,
                                            input logic [11:0] hi, input logic up);
    if (up) return (v >= hi) ? lo : v + 12'd1;
    else    return (v <= lo) ? hi : v - 12'd1;
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, stable-time debouncer, rising-edge press pulse.
module btn_cond #(
  parameter logic [15:0] DEB_CYC = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic        sync1_q, sync2_q, level_q, press_q;
  logic [15:0] cnt_q;
  logic        accept;

  // cnt_q counts consecutive samples that disagree with the accepted level.
  assign accept = (sync2_q != level_q) && (cnt_q == DEB_CYC - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= 16'd0;
      end else if (accept) begin
        cnt_q   <= 16'd0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
      press_q <= accept & sync2_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/watch_setter.sv
// Button-driven time-setting front end: edits a copy of the running time, then loads it back.
module watch_setter
  import watch_pkg::*;
#(
  parameter logic [15:0] DEB_CYC     = 16'd50000,
  parameter logic [5:0]  TIMEOUT_SEC = 6'd30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk1sec,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [11:0] cur_year,
  input  logic [7:0]  cur_month,
  input  logic [7:0]  cur_day,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_minute,
  input  logic [7:0]  cur_second,
  output logic [51:0] bin_time,
  output logic        set_time,
  output logic        editing,
  output logic [2:0]  field
);

  logic [3:0] raw, press;  // 0 mode, 1 next, 2 up, 3 down
  assign raw = {btn_down, btn_up, btn_next, btn_mode};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_cond #(.DEB_CYC(DEB_CYC)) u_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[i]),
      .press (press[i])
    );
  end

  logic [1:0]  state_q, state_d;
  logic [2:0]  field_q, field_d;
  logic [5:0]  tcnt_q, tcnt_d;
  logic [11:0] year_q, year_d;
  logic [7:0]  month_q, month_d, day_q, day_d, hour_q, hour_d;
  logic [7:0]  minute_q, minute_d, second_q, second_d;
  logic [7:0]  mdays;
  logic [11:0] sel_val, sel_lo, sel_hi, stepped;

  assign mdays = max_date(year_q, month_q);

  always_comb begin
    sel_lo = 12'd0;
    case (field_q)
      FldYear:   begin sel_val = year_q;            sel_lo = YearMin; sel_hi = YearMax;   end
      FldMonth:  begin sel_val = {4'd0, month_q};   sel_lo = 12'd1;   sel_hi = MonthMax;  end
      FldDay:    begin sel_val = {4'd0, day_q};     sel_lo = 12'd1;   sel_hi = {4'd0, mdays}; end
      FldHour:   begin sel_val = {4'd0, hour_q};    sel_hi = HourMax;   end
      FldMinute: begin sel_val = {4'd0, minute_q};  sel_hi = MinSecMax; end
      default:   begin sel_val = {4'd0, second_q};  sel_hi = MinSecMax; end
    endcase
    stepped = wrap_step(sel_val, sel_lo, sel_hi, press[2]);
  end

  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    tcnt_d   = tcnt_q;
    year_d   = year_q;
    month_d  = month_q;
    day_d    = day_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    case (state_q)
      StIdle: begin
        if (press[0]) begin
          year_d   = cur_year;
          month_d  = cur_month;
          day_d    = cur_day;
          hour_d   = cur_hour;
          minute_d = cur_minute;
          second_d = cur_second;
          field_d  = FldYear;
          tcnt_d   = 6'd0;
          state_d  = StEdit;
        end
      end
      StEdit: begin
        // Clamp is one cycle behind the month/year step that caused it.
        if (day_q > mdays) day_d = mdays;
        if (|press) begin
          tcnt_d = 6'd0;
        end else if (clk1sec) begin
          tcnt_d = tcnt_q + 6'd1;
          if (tcnt_d >= TIMEOUT_SEC) state_d = StIdle;
        end
        if (press[0]) begin
          state_d = StCommit;
        end else if (press[1]) begin
          field_d = (field_q == FldSecond) ? FldYear : field_q + 3'd1;
        end else if (press[2] || press[3]) begin
          case (field_q)
            FldYear:   year_d   = stepped;
            FldMonth:  month_d  = stepped[7:0];
            FldDay:    day_d    = stepped[7:0];
            FldHour:   hour_d   = stepped[7:0];
            FldMinute: minute_d = stepped[7:0];
            default:   second_d = stepped[7:0];
          endcase
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      field_q  <= FldYear;
      tcnt_q   <= 6'd0;
      year_q   <= RstYear;
      month_q  <= RstMonth;
      day_q    <= RstDay;
      hour_q   <= RstHour;
      minute_q <= RstMinute;
      second_q <= RstSecond;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      tcnt_q   <= tcnt_d;
      year_q   <= year_d;
      month_q  <= month_d;
      day_q    <= day_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      second_q <= second_d;
    end
  end

  assign bin_time = {year_q, month_q, day_q, hour_q, minute_q, second_q};
  assign set_time = (state_q == StCommit);
  assign editing  = (state_q == StEdit);
  assign field    = field_q;

endmodule

// File: tb/tb_watch_setter.sv
// Self-checking bench for watch_setter; committed times are checked through a scoreboard queue.
module tb_watch_setter;

  localparam int Deb = 4;
  localparam int Settle = Deb + 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk1sec = 1'b0;
  logic [3:0]  btn = 4'd0;  // 0 mode, 1 next, 2 up, 3 down
  logic [11:0] cur_year = 12'd0;
  logic [7:0]  cur_month = 8'd0, cur_day = 8'd0, cur_hour = 8'd0;
  logic [7:0]  cur_minute = 8'd0, cur_second = 8'd0;
  logic [51:0] bin_time;
  logic        set_time, editing;
  logic [2:0]  field;

  int n_checks = 0;
  int n_err = 0;
  int n_commit = 0;
  logic set_prev = 1'b0;
  logic [51:0] sb_q[$];

  watch_setter #(.DEB_CYC(16'd4), .TIMEOUT_SEC(6'd30)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk1sec    (clk1sec),
    .btn_mode   (btn[0]),
    .btn_next   (btn[1]),
    .btn_up     (btn[2]),
    .btn_down   (btn[3]),
    .cur_year   (cur_year),
    .cur_month  (cur_month),
    .cur_day    (cur_day),
    .cur_hour   (cur_hour),
    .cur_minute (cur_minute),
    .cur_second (cur_second),
    .bin_time   (bin_time),
    .set_time   (set_time),
    .editing    (editing),
    .field      (field)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [51:0] mk_time(input int y, input int mo, input int d, input int h,
                                          input int mi, input int s);
    return {y[11:0], mo[7:0], d[7:0], h[7:0], mi[7:0], s[7:0]};
  endfunction

  // Scoreboard: every set_time pulse must match the next queued expected time.
  always @(negedge clk) begin
    if (rst && set_time) begin
      n_commit++;
      check_val("set_width", {63'd0, set_prev}, 64'd0);
      if (sb_q.size() == 0) check_val("unexpected_set", 64'd1, 64'd0);
      else check_val("commit_time", {12'd0, bin_time}, {12'd0, sb_q.pop_front()});
    end
    set_prev = set_time;
  end

  task automatic press(input int b);
    @(negedge clk);
    btn[b] = 1'b1;
    repeat (Settle) @(negedge clk);
    btn[b] = 1'b0;
    repeat (Settle) @(negedge clk);
  endtask

  task automatic press_n(input int b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic bounce_press(input int b);
    @(negedge clk);
    btn[b] = 1'b1;
    @(negedge clk);
    btn[b] = 1'b0;
    @(negedge clk);
    btn[b] = 1'b1;
    repeat (Settle) @(negedge clk);
    btn[b] = 1'b0;
    repeat (Settle) @(negedge clk);
  endtask

  task automatic pulse_sec(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clk1sec = 1'b1;
      @(negedge clk);
      clk1sec = 1'b0;
    end
  endtask

  task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi,
                         input int s);
    {cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second} = mk_time(y, mo, d, h, mi, s);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_editing", {63'd0, editing}, 64'd0);
    check_val("rst_time", {12'd0, bin_time}, {12'd0, mk_time(2021, 5, 30, 0, 0, 0)});
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_field", {61'd0, field}, 64'd0);

    // Enter edit with a leap-day running time.
    set_cur(2024, 2, 29, 10, 20, 30);
    press(0);
    check_val("enter_editing", {63'd0, editing}, 64'd1);
    check_val("enter_field", {61'd0, field}, 64'd0);
    check_val("enter_time", {12'd0, bin_time}, {12'd0, mk_time(2024, 2, 29, 10, 20, 30)});
    set_cur(1999, 7, 7, 7, 7, 7);
    repeat (3) @(negedge clk);
    check_val("no_follow", {12'd0, bin_time}, {12'd0, mk_time(2024, 2, 29, 10, 20, 30)});

    // Year up: the step lands first, the day clamp one cycle later.
    @(negedge clk);
    btn[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bin_time[51:40] != 12'd2024) break;
    end
    check_val("year_up", {52'd0, bin_time[51:40]}, 64'd2025);
    check_val("day_preclamp", {56'd0, bin_time[31:24]}, 64'd29);
    @(negedge clk);
    check_val("day_clamp", {56'd0, bin_time[31:24]}, 64'd28);
    repeat (Settle) @(negedge clk);
    btn[2] = 1'b0;
    repeat (Settle) @(negedge clk);

    press_n(1, 5);
    check_val("field_5", {61'd0, field}, 64'd5);
    press_n(2, 29);
    check_val("sec_59", {56'd0, bin_time[7:0]}, 64'd59);
    press(2);
    check_val("sec_wrap", {56'd0, bin_time[7:0]}, 64'd0);
    press(1);
    check_val("field_wrap", {61'd0, field}, 64'd0);

    sb_q.push_back(mk_time(2025, 2, 28, 10, 20, 0));
    press(0);
    check_val("commit_idle", {63'd0, editing}, 64'd0);
    check_val("commit_n", n_commit, 64'd1);

    // Year/month lower-bound wraps, then idle timeout with a restart at pulse 29.
    set_cur(1, 1, 15, 5, 6, 7);
    press(0);
    press(3);
    check_val("year_wrap", {12'd0, bin_time}, {12'd0, mk_time(4095, 1, 15, 5, 6, 7)});
    press(1);
    press(3);
    check_val("month_dn_wrap", {56'd0, bin_time[39:32]}, 64'd12);
    press(2);
    check_val("month_up_wrap", {56'd0, bin_time[39:32]}, 64'd1);
    pulse_sec(29);
    check_val("to_29_edit", {63'd0, editing}, 64'd1);
    press(1);
    pulse_sec(29);
    check_val("to_restart", {63'd0, editing}, 64'd1);
    pulse_sec(1);
    check_val("to_idle", {63'd0, editing}, 64'd0);

    // Bouncing buttons give one event each; up beats down in the same cycle.
    set_cur(2023, 3, 31, 12, 0, 0);
    bounce_press(0);
    check_val("bounce_mode", {63'd0, editing}, 64'd1);
    check_val("bounce_field0", {61'd0, field}, 64'd0);
    bounce_press(1);
    check_val("bounce_next", {61'd0, field}, 64'd1);
    @(negedge clk);
    btn[2] = 1'b1;
    btn[3] = 1'b1;
    repeat (Settle) @(negedge clk);
    btn = 4'd0;
    repeat (Settle) @(negedge clk);
    check_val("up_over_down", {12'd0, bin_time}, {12'd0, mk_time(2023, 4, 30, 12, 0, 0)});

    // Asynchronous reset abandons the edit.
    #2 rst = 1'b0;
    #1;
    check_val("arst_editing", {63'd0, editing}, 64'd0);
    check_val("arst_time", {12'd0, bin_time}, {12'd0, mk_time(2021, 5, 30, 0, 0, 0)});
    check_val("arst_field", {61'd0, field}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_val("post_rst_idle", {63'd0, editing}, 64'd0);
    check_val("sb_drain", sb_q.size(), 64'd0);
    check_val("commit_total", n_commit, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/watch_setter.md
WATCH_SETTER -- requirements
Module: watch_setter

Interface
REQ-001 Parameter DEB_CYC, default 16'd50000: debounce stable-time in clk cycles.
REQ-002 Parameter TIMEOUT_SEC, default 6'd30: idle seconds in edit before abort.
REQ-003 clk  input  1  system clock; all state on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 clk1sec  input  1  one-clk-wide pulse, once per second.
REQ-006 btn_mode, btn_next, btn_up, btn_down  input  1 each  raw push-buttons, active-high, asynchronous to clk.
REQ-007 cur_year  input  12  running year from the timekeeper.
REQ-008 cur_month, cur_day, cur_hour, cur_minute, cur_second  input  8 each  running time from the timekeeper.
REQ-009 bin_time  output  52  {year[11:0], month, day, hour, minute, second} edit buffer.
REQ-010 set_time  output  1  one-cycle load strobe to the timekeeper.
REQ-011 editing  output  1  high while in EDIT.
REQ-012 field  output  3  field under edit: 0 year, 1 month, 2 day, 3 hour, 4 minute, 5 second.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEB_CYC consecutive equal samples; a 0->1 debounced transition SHALL produce a one-cycle press event; latency raw-stable to event SHALL be DEB_CYC+3 cycles max.
REQ-014 FSM states SHALL be IDLE, EDIT, COMMIT.
REQ-015 IDLE: mode press SHALL copy cur_* into the edit buffer, set field=0, clear timeout counter, enter EDIT next cycle.
REQ-016 EDIT: exactly one event acted on per cycle, priority mode > next > up > down; lower-priority simultaneous events SHALL be dropped.
REQ-017 EDIT next: field SHALL advance 0..5, wrapping 5->0.
REQ-018 EDIT up/down SHALL step the selected field by 1 with wrap: year 1..4095, month 1..12, day 1..max_date, hour 0..23, minute 0..59, second 0..59 (4095 up -> 1; 1 down -> 4095; 59 up -> 0; 0 down -> 59).
REQ-019 max_date SHALL be computed from buffer year/month: 31/30 per month, February 29 when (y%4==0 and y%100!=0) or y%400==0, else 28.
REQ-020 If a month or year step makes day > max_date, day SHALL be clamped to max_date on the following cycle.
REQ-021 EDIT mode press SHALL enter COMMIT.
REQ-022 COMMIT: set_time SHALL be 1 for exactly one cycle with bin_time equal to the buffer; next state IDLE.
REQ-023 Timeout counter SHALL increment on clk1sec in EDIT, clear on any press event; reaching TIMEOUT_SEC SHALL return to IDLE with no set_time.
REQ-024 Outside COMMIT set_time SHALL be 0; bin_time SHALL always reflect the buffer.
REQ-025 Buffer SHALL NOT follow cur_* except at EDIT entry.

Reset
REQ-026 On rst low, asynchronously: state IDLE, set_time 0, editing 0, field 0, buffer {2021,5,30,0,0,0}, timeout counter 0, debouncers/synchronizers 0.
REQ-027 Reset mid-EDIT or mid-COMMIT SHALL abandon the edit; no set_time pulse after release.

Structure
REQ-028 Package watch_pkg SHALL hold field encodings, FSM state encodings, field limits, reset time constants and the leap-year/max-date function.
REQ-029 Sub-module btn_cond (synchronizer + debounce + edge detect, parameter DEB_CYC) SHALL be instantiated once per button.

Verification (DEB_CYC=4 in bench)
REQ-030 IDLE, cur=2024-02-29 10:20:30, mode -> editing=1, field=0, bin_time={2024,2,29,10,20,30}.
REQ-031 In EDIT field=0 year 2024, up -> year 2025, day clamps 29->28 next cycle.
REQ-032 field=5 second 59, up -> 0; field=0 year 1, down -> 4095; next at field 5 -> field 0.
REQ-033 EDIT, mode -> set_time high exactly one cycle, bin_time=buffer, then IDLE, editing=0.
REQ-034 EDIT, 30 clk1sec pulses no press -> IDLE, set_time never asserted; press at pulse 29 restarts count.
REQ-035 Button bouncing 3 cycles then stable -> exactly one event; up+down same cycle -> only up applied; rst low in EDIT -> IDLE, buffer 2021-05-30 00:00:00.
